// File: rtl/cache_refill_unit.sv
// Miss handler: optional word-by-word victim write-back, then in-order refill of the
// missing line through the fill port, one outstanding memory read at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a miss request, req_ready high
//   WB_REQ  | presenting victim word idx as a memory write
//   RD_REQ  | presenting line word idx as a memory read
//   RD_WAIT | read outstanding, waiting for response to fill word idx
//   DONE    | one-cycle completion pulse
module cache_refill_unit #(
  parameter int BLOCK_OFFSET_BITS = 6,
  parameter int WORDS_PER_BLOCK   = 16,
  parameter int IDX_BITS          = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_wb,
  input  logic [31:0]         req_wb_addr,
  output logic [IDX_BITS-1:0] vic_rd_idx,
  input  logic [31:0]         vic_rd_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [31:0]         mem_req_addr,
  output logic [31:0]         mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_rdata,
  output logic                fill_valid,
  output logic [IDX_BITS-1:0] fill_idx,
  output logic [31:0]         fill_data,
  output logic                done,
  output logic                busy
);

  localparam int LINE_BITS = 32 - BLOCK_OFFSET_BITS;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_BITS-1:0]   idx, idx_nxt;
  logic [LINE_BITS-1:0]  miss_line, wb_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      miss_line <= '0;
      wb_line   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (req_valid && req_ready) begin
        miss_line <= req_addr[31:BLOCK_OFFSET_BITS];
        wb_line   <= req_wb_addr[31:BLOCK_OFFSET_BITS];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    req_ready     = 1'b0;
    busy          = 1'b1;
    vic_rd_idx    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_valid    = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          idx_nxt   = '0;
          state_nxt = req_wb ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {wb_line, idx, 2'b00};
        mem_req_wdata = vic_rd_data;
        vic_rd_idx    = idx;
        if (mem_req_ready) begin
          // idx wraps to 0 after the last victim word, ready for the refill pass
          idx_nxt = idx + 1'b1;
          if (idx == IDX_LAST) state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {miss_line, idx, 2'b00};
        if (mem_req_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          fill_valid = 1'b1;
          fill_idx   = idx;
          fill_data  = mem_rsp_rdata;
          if (idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = RD_REQ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: a memory model with configurable
// backpressure and response delay, and queues of expected writes, reads and fills.
module tb_cache_refill_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wb;
  logic [31:0] req_wb_addr;
  logic [3:0]  vic_rd_idx;
  logic [31:0] vic_rd_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        fill_valid;
  logic [3:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done;
  logic        busy;

  cache_refill_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr),
    .vic_rd_idx(vic_rd_idx), .vic_rd_data(vic_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Victim data array: word i of the dirty line holds 0xA0 + i.
  assign vic_rd_data = 32'h0000_00A0 + {28'd0, vic_rd_idx};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // memory model configuration
  int          stall_n   = 0;
  int          rsp_delay = 1;
  bit          spurious  = 1'b0;
  bit          model_en  = 1'b1;
  logic [31:0] data_base = 32'h0;

  logic [63:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [35:0] exp_fill_q[$];
  int          acc_q[$];
  int          done_q[$];
  int          busy_low_q[$];
  int          fill_cnt   = 0;
  bit          fill7_seen = 1'b0;

  int          stall_cnt = 0;
  int          rsp_cnt   = 0;
  logic [31:0] rsp_addr;
  bit          held = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [63:0] e_wr;
  logic [31:0] e_rd;
  logic [35:0] e_fill;

  // Memory model and output monitor: inputs driven on the falling edge, outputs sampled 1 ns later.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'h0;
      if (!model_en) begin
        rsp_cnt       = 0;
        stall_cnt     = 0;
        held          = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = data_base + {26'd0, rsp_addr[5:0]};
          end
        end else if (spurious && mem_req_valid && !mem_req_we) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 32'hDEAD_BEEF;
        end
        if (mem_req_valid) begin
          if (stall_cnt < stall_n) begin
            mem_req_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_req_ready = 1'b1;
            stall_cnt     = 0;
          end
        end else begin
          mem_req_ready = 1'b0;
        end
      end
      #1;
      if (held) begin
        check("hold_valid", mem_req_valid, 1'b1);
        check("hold_addr", mem_req_addr, held_addr);
        check("hold_wdata", mem_req_wdata, held_wdata);
      end
      held = 1'b0;
      if (!reset && model_en) begin
        if (mem_req_valid && !mem_req_ready) begin
          held       = 1'b1;
          held_addr  = mem_req_addr;
          held_wdata = mem_req_wdata;
        end
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_we) begin
            check("wr_pending", exp_wr_q.size() > 0, 1'b1);
            if (exp_wr_q.size() > 0) begin
              e_wr = exp_wr_q.pop_front();
              check("wr_addr", mem_req_addr, e_wr[63:32]);
              check("wr_data", mem_req_wdata, e_wr[31:0]);
              check("vic_rd_idx", vic_rd_idx, e_wr[37:34]);
            end
          end else begin
            check("rd_pending", exp_rd_q.size() > 0, 1'b1);
            if (exp_rd_q.size() > 0) begin
              e_rd = exp_rd_q.pop_front();
              check("rd_addr", mem_req_addr, e_rd);
            end
            rsp_addr = mem_req_addr;
            rsp_cnt  = rsp_delay;
          end
        end
        if (!mem_req_valid) check("idle_we_wdata", {mem_req_we, mem_req_wdata}, 33'd0);
        if (!(mem_req_valid && mem_req_we)) check("vic_idx_idle", vic_rd_idx, 4'd0);
        if (fill_valid) begin
          check("fill_pending", exp_fill_q.size() > 0, 1'b1);
          if (exp_fill_q.size() > 0) begin
            e_fill = exp_fill_q.pop_front();
            check("fill_idx", fill_idx, e_fill[35:32]);
            check("fill_data", fill_data, e_fill[31:0]);
          end
          fill_cnt++;
          if (fill_idx == 4'd7) fill7_seen = 1'b1;
        end
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (!busy) busy_low_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic push_miss(input logic [31:0] addr, input bit wb, input logic [31:0] wb_addr,
                           input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      if (wb) exp_wr_q.push_back({wb_addr[31:6], i[3:0], 2'b00, 32'h0000_00A0 + i});
      exp_rd_q.push_back({addr[31:6], i[3:0], 2'b00});
      exp_fill_q.push_back({i[3:0], base + 32'(4 * i)});
    end
  endtask

  task automatic issue_req(input logic [31:0] addr, input bit wb, input logic [31:0] wb_addr);
    int n0;
    n0 = acc_q.size();
    @(negedge clk);
    req_addr    = addr;
    req_wb      = wb;
    req_wb_addr = wb_addr;
    req_valid   = 1'b1;
    #2;
    for (int t = 0; t < 20 && acc_q.size() == n0; t++) begin
      @(negedge clk); #2;
    end
    check("req_accept", acc_q.size(), n0 + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int exp_lat);
    for (int t = 0; t < 1000 && done_q.size() == n0; t++) begin
      @(negedge clk); #2;
    end
    check("done_seen", done_q.size(), n0 + 1);
    if (done_q.size() > n0 && exp_lat > 0)
      check("latency", done_q[n0] - acc_q[acc_q.size() - 1], exp_lat);
  endtask

  task automatic run_miss(input logic [31:0] addr, input bit wb, input logic [31:0] wb_addr,
                          input logic [31:0] base, input int exp_lat);
    int n_done, n_fill;
    n_done    = done_q.size();
    n_fill    = fill_cnt;
    data_base = base;
    push_miss(addr, wb, wb_addr, base);
    issue_req(addr, wb, wb_addr);
    wait_done(n_done, exp_lat);
    check("fill_count", fill_cnt - n_fill, 16);
    check("wr_left", exp_wr_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("fill_left", exp_fill_q.size(), 0);
    @(negedge clk); #2;
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", {req_ready, busy}, 2'b10);
  endtask

  int acc1, acc2, done1, n_low, n_done0;

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = 32'h0;
    req_wb      = 1'b0;
    req_wb_addr = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_vic_idx", vic_rd_idx, 4'd0);
    reset = 1'b0;

    // clean miss: accept and done cycles inclusive span 34 cycles
    run_miss(32'h0000_0440, 1'b0, 32'h0, 32'h0000_1000, 33);
    // dirty miss, unaligned request address
    run_miss(32'h0000_1C3B, 1'b1, 32'h0000_0800, 32'h0000_2000, 49);
    // backpressure: three stall cycles on each of 32 requests
    stall_n = 3;
    run_miss(32'h0000_1240, 1'b1, 32'h0000_2AC0, 32'h0000_3000, 145);
    stall_n = 0;
    // slow responses with spurious pulses while the read request is presented
    rsp_delay = 5;
    spurious  = 1'b1;
    run_miss(32'h0000_3F00, 1'b0, 32'h0, 32'h0000_5000, 97);
    rsp_delay = 1;
    spurious  = 1'b0;

    // reset in the middle of a refill
    fill7_seen = 1'b0;
    data_base  = 32'h0000_9000;
    push_miss(32'h0000_5500, 1'b0, 32'h0, 32'h0000_9000);
    issue_req(32'h0000_5500, 1'b0, 32'h0);
    for (int t = 0; t < 200 && !fill7_seen; t++) begin
      @(negedge clk); #2;
    end
    check("fill7_reached", fill7_seen, 1'b1);
    reset    = 1'b1;
    model_en = 1'b0;
    @(negedge clk); #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_fill", fill_valid, 1'b0);
    check("midrst_mem_valid", mem_req_valid, 1'b0);
    reset = 1'b0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_fill_q.delete();
    model_en = 1'b1;
    run_miss(32'h0000_6600, 1'b0, 32'h0, 32'h0000_A000, 33);

    // back-to-back requests with req_valid held across done
    data_base = 32'h0000_B000;
    n_done0   = done_q.size();
    push_miss(32'h0000_0040, 1'b0, 32'h0, 32'h0000_B000);
    push_miss(32'h0000_7780, 1'b1, 32'h0000_0C00, 32'h0000_B000);
    issue_req(32'h0000_0040, 1'b0, 32'h0);
    req_addr    = 32'h0000_7780;
    req_wb      = 1'b1;
    req_wb_addr = 32'h0000_0C00;
    req_valid   = 1'b1;
    acc1 = acc_q[acc_q.size() - 1];
    wait_done(n_done0, 33);
    for (int t = 0; t < 5 && acc_q.size() < 2 + acc_q.size() - 1 && acc_q[acc_q.size() - 1] == acc1; t++) begin
      @(negedge clk); #2;
    end
    acc2  = acc_q[acc_q.size() - 1];
    done1 = (done_q.size() > n_done0) ? done_q[n_done0] : 0;
    check("b2b_second_accept", acc2 - done1, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_low = 0;
    foreach (busy_low_q[k]) if (busy_low_q[k] > acc1 && busy_low_q[k] < acc2) n_low++;
    check("b2b_busy_gap", n_low, 0);
    wait_done(n_done0 + 1, 49);
    check("b2b_wr_left", exp_wr_q.size(), 0);
    check("b2b_rd_left", exp_rd_q.size(), 0);
    check("b2b_fill_left", exp_fill_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
